// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a 4:1 mux through channels 0..3 and captures its output as a 4-bit word
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
  output logic       sel1,
  output logic       sel0,
  output logic       busy,
  output logic       done,
  output logic [3:0] data
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [1:0]      ch;
  logic [1:0]      ch_n;
  logic [DW_W-1:0] dwell_cnt;
  logic [DW_W-1:0] dwell_cnt_n;
  logic [3:0]      shadow;
  logic [3:0]      shadow_n;
  logic [3:0]      data_n;
  logic [1:0]      sel_n;
  logic            busy_n;
  logic            done_n;

  // Next-state, counters and capture; registered outputs are derived from the next state
  // so that sel/busy/done all change on the same edge as the state itself.
  always_comb begin
    state_n     = state;
    ch_n        = ch;
    dwell_cnt_n = dwell_cnt;
    shadow_n    = shadow;
    data_n      = data;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SCAN;
          ch_n        = 2'd0;
          dwell_cnt_n = '0;
        end
      end
      SCAN: begin
        if (dwell_cnt == DWELL_LAST) begin
          shadow_n[ch] = f;
          dwell_cnt_n  = '0;
          if (ch == 2'd3) begin
            // Channel 3's sample goes straight into data alongside the shadow bits.
            state_n = DONE;
            data_n  = shadow_n;
          end else begin
            ch_n = ch + 2'd1;
          end
        end else begin
          dwell_cnt_n = dwell_cnt + DW_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    sel_n  = (state_n == SCAN) ? ch_n : 2'b00;
    busy_n = (state_n == SCAN);
    done_n = (state_n == DONE);
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= 2'd0;
      dwell_cnt <= '0;
      shadow    <= 4'b0000;
      data      <= 4'b0000;
      sel1      <= 1'b0;
      sel0      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      dwell_cnt <= dwell_cnt_n;
      shadow    <= shadow_n;
      data      <= data_n;
      sel1      <= sel_n[1];
      sel0      <= sel_n[0];
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for mux_scan_ctrl at DWELL 2, 3 and 1
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] start;
  logic [3:0] ins [3];
  wire  [2:0] f;
  wire  [2:0] sel1;
  wire  [2:0] sel0;
  wire  [2:0] busy;
  wire  [2:0] done;
  wire  [3:0] data [3];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt [3];
  logic [3:0] exp_q0 [$];
  logic [3:0] exp_q1 [$];
  logic [3:0] exp_q2 [$];

  mux_scan_ctrl #(.DWELL(2)) u_d2 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .f(f[0]),
    .sel1(sel1[0]), .sel0(sel0[0]), .busy(busy[0]), .done(done[0]), .data(data[0])
  );
  mux_scan_ctrl #(.DWELL(3)) u_d3 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .f(f[1]),
    .sel1(sel1[1]), .sel0(sel0[1]), .busy(busy[1]), .done(done[1]), .data(data[1])
  );
  mux_scan_ctrl #(.DWELL(1)) u_d1 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .f(f[2]),
    .sel1(sel1[2]), .sel0(sel0[2]), .busy(busy[2]), .done(done[2]), .data(data[2])
  );

  // Behavioural 4:1 muxes feeding each controller.
  assign f[0] = ins[0][{sel1[0], sel0[0]}];
  assign f[1] = ins[1][{sel1[1], sel0[1]}];
  assign f[2] = ins[2][{sel1[2], sel0[2]}];

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [3:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [3:0] pop(input int k);
    case (k)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  task automatic wait_done(input int k, input int max);
    int n = 0;
    while (!done[k] && n < max) begin
      cyc();
      n++;
    end
    check($sformatf("u%0d_done_timeout", k), done[k], 1);
  endtask

  // Scoreboard: every done strobe must match the oldest expected word.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k]) begin
        done_cnt[k]++;
        if (qsize(k) == 0) check($sformatf("u%0d_unexpected_done", k), done[k], 0);
        else check($sformatf("u%0d_data", k), data[k], pop(k));
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0;
      ins[k] = 4'b0000;
    end
    rst = 3'b111;
    start = 3'b000;

    // Reset held with start high: outputs stay cleared.
    ins[0] = 4'b1101;
    start[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst_outs", {sel1[0], sel0[0], busy[0], done[0], data[0]}, 0);
    end

    // Release with start still high: scan starts at the next edge.
    rst = 3'b000;
    push(0, 4'b1101);
    cyc();
    start[0] = 1'b0;
    check("t0_busy", busy[0], 1);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("scan_sel_c%0d", c), {sel1[0], sel0[0]}, c / 2);
      check($sformatf("scan_busy_c%0d", c), busy[0], 1);
      if (c == 3) start[0] = 1'b1;
      if (c == 4) start[0] = 1'b0;
      cyc();
    end
    check("t8_done", done[0], 1);
    check("t8_busy", busy[0], 0);
    check("t8_sel", {sel1[0], sel0[0]}, 0);
    start[0] = 1'b1;
    cyc();
    check("t9_done_low", done[0], 0);
    check("t9_busy_low", busy[0], 0);
    check("t9_data_held", data[0], 4'b1101);
    cyc();
    check("t10_accept", busy[0], 1);
    check("t10_sel", {sel1[0], sel0[0]}, 0);
    check("single_done", done_cnt[0], 1);
    start[0] = 1'b0;
    push(0, 4'b1101);
    wait_done(0, 20);
    cyc();

    // Reset mid-scan aborts, clears data and suppresses done.
    ins[0] = 4'b1111;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (4) cyc();
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    check("midrst_outs", {sel1[0], sel0[0], busy[0], done[0], data[0]}, 0);
    repeat (3) cyc();
    check("midrst_idle", busy[0], 0);
    check("midrst_no_done", done_cnt[0], 2);
    push(0, 4'b1111);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    wait_done(0, 20);
    cyc();

    // DWELL=3: only the last cycle of channel 1's window matters.
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    push(1, 4'b0010);
    repeat (5) cyc();
    check("d3_sel_ch1", {sel1[1], sel0[1]}, 1);
    ins[1][1] = 1'b1;
    cyc();
    check("d3_sel_ch2", {sel1[1], sel0[1]}, 2);
    ins[1][1] = 1'b0;
    repeat (2) cyc();
    ins[1][1] = 1'b1;
    cyc();
    ins[1][1] = 1'b0;
    repeat (3) cyc();
    check("d3_done_t12", done[1], 1);
    cyc();

    // DWELL=1 with start held: period of 6 cycles.
    ins[2] = 4'b0110;
    start[2] = 1'b1;
    push(2, 4'b0110);
    push(2, 4'b0110);
    cyc();
    for (int c = 0; c < 7; c++) begin
      check($sformatf("d1_busy_c%0d", c), busy[2], ((c < 4) || (c == 6)) ? 1 : 0);
      check($sformatf("d1_done_c%0d", c), done[2], (c == 4) ? 1 : 0);
      if (c < 4) check($sformatf("d1_sel_c%0d", c), {sel1[2], sel0[2]}, c);
      if (c == 6) start[2] = 1'b0;
      if (c < 6) cyc();
    end
    repeat (4) cyc();
    check("d1_done_t10", done[2], 1);
    cyc();
    check("d1_done_count", done_cnt[2], 2);

    repeat (3) cyc();
    check("q0_empty", qsize(0), 0);
    check("q1_empty", qsize(1), 0);
    check("q2_empty", qsize(2), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
